xform_mb_scheduler: RTL and testbench

- Sequences the blocks of one macroblock through the shared 4x4 forward-transform unit.
- Per block: fetches the src/ref pixel pair from the macroblock buffer, issues `start` to the transform, waits for `done`, then hands the 16 captured coefficients to the quantiser over a valid/ready interface.
- Sits between the macroblock pixel buffer and the quantiser, and is the sole owner of the transform unit.

---
 rtl/xform_mb_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_xform_mb_scheduler.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xform_mb_scheduler.sv
// Purpose: walks the blocks of one macroblock through the shared 4x4 forward transform and hands coefficients to the quantiser.
// Latency: 6 cycles per block with the quantiser ready (READ, LOAD, ISSUE, 2x WAIT, OUT); mb_done one cycle after the last handshake.
// Backpressure: coef_valid/coef_idx/coef_data hold while coef_ready is low; new jobs are refused (mb_ready=0) until the scheduler is idle.
module xform_mb_scheduler #(
    parameter int BIT_WIDTH  = 8,
    parameter int BLOCK_SIZE = 4,
    parameter int MAX_BLK    = 24,
    parameter int TIMEOUT    = 15
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              mb_valid,
    output logic                                              mb_ready,
    input  logic [4:0]                                        mb_nblk,
    output logic                                              rd_en,
    output logic [4:0]                                        rd_idx,
    input  logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0]        rd_src,
    input  logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0]        rd_ref,
    output logic                                              tr_start,
    output logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0]        tr_src,
    output logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0]        tr_ref,
    input  logic [(BIT_WIDTH+4)*BLOCK_SIZE*BLOCK_SIZE-1:0]    tr_out,
    input  logic                                              tr_done,
    output logic                                              coef_valid,
    input  logic                                              coef_ready,
    output logic [4:0]                                        coef_idx,
    output logic [(BIT_WIDTH+4)*BLOCK_SIZE*BLOCK_SIZE-1:0]    coef_data,
    output logic                                              mb_done,
    output logic                                              err
);

    localparam int NSAMP  = BLOCK_SIZE * BLOCK_SIZE;
    localparam int PIX_W  = BIT_WIDTH * NSAMP;
    localparam int COEF_W = (BIT_WIDTH + 4) * NSAMP;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [4:0]          r_idx;
    logic [4:0]          r_nblk;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_err;
    logic [PIX_W-1:0]    r_tr_src;
    logic [PIX_W-1:0]    r_tr_ref;
    logic [COEF_W-1:0]   r_coef_data;
    logic [4:0]          r_coef_idx;

    logic                w_accept;
    logic                w_timeout;
    logic                w_last;
    logic [4:0]          w_nblk_clamp;

    // A zero or oversized block count means "the whole macroblock".
    assign w_nblk_clamp = ((mb_nblk == 5'd0) || (32'(mb_nblk) > MAX_BLK)) ? 5'(MAX_BLK) : mb_nblk;
    assign w_last       = (r_idx == (r_nblk - 5'd1));

    assign tr_src    = r_tr_src;
    assign tr_ref    = r_tr_ref;
    assign coef_data = r_coef_data;
    assign coef_idx  = r_coef_idx;
    assign err       = r_err;

    // State register; reset abandons any job in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and Moore-style strobes for buffer, transform and quantiser.
    always_comb begin
        w_state_nxt = r_state;
        mb_ready    = 1'b0;
        rd_en       = 1'b0;
        rd_idx      = 5'd0;
        tr_start    = 1'b0;
        coef_valid  = 1'b0;
        mb_done     = 1'b0;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                mb_ready = 1'b1;
                if (mb_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                rd_en       = 1'b1;
                rd_idx      = r_idx;
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                tr_start    = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (tr_done) begin
                    w_state_nxt = S_OUT;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    // Transform is hung: abandon the rest of the macroblock.
                    w_timeout   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_OUT: begin
                coef_valid = 1'b1;
                if (coef_ready) begin
                    w_state_nxt = w_last ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                mb_done     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Job bookkeeping: block count, block index and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nblk <= 5'd0;
            r_idx  <= 5'd0;
            r_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_nblk <= w_nblk_clamp;
                r_idx  <= 5'd0;
                r_err  <= 1'b0;
            end else if (w_timeout) begin
                r_err  <= 1'b1;
            end
            if ((r_state == S_OUT) && coef_ready && !w_last) begin
                r_idx <= r_idx + 5'd1;
            end
        end
    end

    // Timeout counter: cleared when the transform is started, counts WAIT cycles without done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_cnt <= '0;
        end else if ((r_state == S_WAIT) && !tr_done) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Transform operands: loaded from the buffer read data, then held until the next block's load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tr_src <= '0;
            r_tr_ref <= '0;
        end else if (r_state == S_LOAD) begin
            r_tr_src <= rd_src;
            r_tr_ref <= rd_ref;
        end
    end

    // Coefficient capture: only a done seen in WAIT is taken; stays stable through OUT backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_coef_data <= '0;
            r_coef_idx  <= 5'd0;
        end else if ((r_state == S_WAIT) && tr_done) begin
            r_coef_data <= tr_out;
            r_coef_idx  <= r_idx;
        end
    end

endmodule

// File: tb/tb_xform_mb_scheduler.sv
module tb_xform_mb_scheduler;

    localparam int MAXB = 24;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mb_valid = 1'b0;
    logic         mb_ready;
    logic [4:0]   mb_nblk = 5'd0;
    logic         rd_en;
    logic [4:0]   rd_idx;
    logic [127:0] rd_src = '0;
    logic [127:0] rd_ref = '0;
    logic         tr_start;
    logic [127:0] tr_src;
    logic [127:0] tr_ref;
    logic [191:0] tr_out = '0;
    logic         tr_done = 1'b0;
    logic         coef_valid;
    logic         coef_ready = 1'b1;
    logic [4:0]   coef_idx;
    logic [191:0] coef_data;
    logic         mb_done;
    logic         err;

    int total = 0;
    int bad = 0;

    xform_mb_scheduler dut (
        .clk(clk), .rst(rst), .mb_valid(mb_valid), .mb_ready(mb_ready), .mb_nblk(mb_nblk),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_src(rd_src), .rd_ref(rd_ref),
        .tr_start(tr_start), .tr_src(tr_src), .tr_ref(tr_ref), .tr_out(tr_out), .tr_done(tr_done),
        .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_idx(coef_idx), .coef_data(coef_data),
        .mb_done(mb_done), .err(err)
    );

    always #5 clk = ~clk;

    // Environment state: pixel buffer contents and transform model.
    logic [127:0] src_mem [MAXB];
    logic [127:0] ref_mem [MAXB];
    bit           rd_pend = 0;
    logic [4:0]   rd_pend_idx = 5'd0;
    int           tr_cnt = 0;
    logic [191:0] tr_pend = '0;
    bit           tr_never = 0;
    bit           spur = 0;

    // Observations of one job.
    int           hs_cyc[$];
    int           hs_idx[$];
    logic [191:0] hs_dat[$];
    int           rd_cyc[$];
    int           rd_ix[$];
    int           done_cyc[$];
    int           start_cnt, stall_cnt, stall_viol, drop_viol, ready_cyc;
    bit           err_c1, err_done, timed_out, acc_ok;

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [191:0] rnd192();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Golden 4x4 integer forward transform Y = C*(src-ref)*C^T, coefficients kept to 12 bits.
    function automatic logic [191:0] fwd(input logic [127:0] s, input logic [127:0] r);
        int c [4][4] = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};
        int d [4][4];
        int t [4][4];
        int y;
        logic [191:0] o;
        o = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                d[i][j] = int'(s[(i*4+j)*8 +: 8]) - int'(r[(i*4+j)*8 +: 8]);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                t[i][j] = 0;
                for (int k = 0; k < 4; k++) t[i][j] += c[i][k] * d[k][j];
            end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                y = 0;
                for (int k = 0; k < 4; k++) y += t[i][k] * c[j][k];
                o[(i*4+j)*12 +: 12] = y[11:0];
            end
        return o;
    endfunction

    function automatic int clamp_n(input int n);
        return (n == 0 || n > MAXB) ? MAXB : n;
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < MAXB; i++) begin
            src_mem[i] = rnd128();
            ref_mem[i] = rnd128();
        end
    endtask

    // Advance one cycle; then play pixel buffer and transform for the cycle just entered.
    task automatic step();
        @(posedge clk);
        #1;
        if (rd_pend) begin
            rd_src = src_mem[rd_pend_idx];
            rd_ref = ref_mem[rd_pend_idx];
        end else begin
            rd_src = rnd128();
            rd_ref = rnd128();
        end
        rd_pend     = rd_en;
        rd_pend_idx = rd_idx;
        tr_done = 1'b0;
        tr_out  = rnd192();
        if (tr_cnt > 0) begin
            tr_cnt--;
            if (tr_cnt == 0) begin
                tr_done = 1'b1;
                tr_out  = tr_pend;
            end
        end
        if (tr_start && !tr_never) begin
            tr_cnt  = 2;
            tr_pend = fwd(tr_src, tr_ref);
        end
        if (spur && (coef_valid || mb_ready)) tr_done = 1'b1;
    endtask

    // Offer one job in the current (idle) cycle, cycle 0, and record what happens until mb_ready returns.
    task automatic run_job(input int nb, input bit keep_vld, input int bp_blk, input int bp_len,
                           input bit rand_rdy, input int budget);
        int cyc = 0;
        int held = 0;
        bit pv = 0;
        bit pr = 1;
        logic [4:0] pidx = 5'd0;
        logic [191:0] pdat = '0;
        hs_cyc.delete(); hs_idx.delete(); hs_dat.delete();
        rd_cyc.delete(); rd_ix.delete(); done_cyc.delete();
        start_cnt = 0; stall_cnt = 0; stall_viol = 0; drop_viol = 0; ready_cyc = -1;
        err_c1 = 0; err_done = 0; timed_out = 0;
        acc_ok     = mb_ready;
        mb_nblk    = 5'(nb);
        mb_valid   = 1'b1;
        coef_ready = 1'b1;
        forever begin
            step();
            cyc++;
            mb_valid = keep_vld;
            if (cyc == 1) err_c1 = err;
            if (tr_start) start_cnt++;
            if (rd_en) begin
                rd_cyc.push_back(cyc);
                rd_ix.push_back(int'(rd_idx));
            end
            if (mb_done) begin
                done_cyc.push_back(cyc);
                err_done = err;
            end
            if (pv && !pr) begin
                if (!coef_valid) drop_viol++;
                else if (coef_idx !== pidx || coef_data !== pdat) stall_viol++;
            end
            coef_ready = rand_rdy ? 1'($urandom_range(0, 2) != 0) : 1'b1;
            if (coef_valid && int'(coef_idx) == bp_blk && held < bp_len) begin
                coef_ready = 1'b0;
                held++;
            end
            if (coef_valid) begin
                if (coef_ready) begin
                    hs_cyc.push_back(cyc);
                    hs_idx.push_back(int'(coef_idx));
                    hs_dat.push_back(coef_data);
                end else begin
                    stall_cnt++;
                end
            end
            pv = coef_valid; pr = coef_ready; pidx = coef_idx; pdat = coef_data;
            if (mb_ready) begin
                ready_cyc = cyc;
                mb_valid  = 1'b0;
                break;
            end
            if (cyc >= budget) begin
                timed_out = 1;
                mb_valid  = 1'b0;
                break;
            end
        end
        coef_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (mb_ready !== 1'b1) begin bad++; $display("FAIL reset_mb_ready: got %b want 1", mb_ready); end
        total++; if ({rd_en, tr_start, coef_valid, mb_done, err} !== 5'b0) begin bad++;
            $display("FAIL reset_strobes: got %b want 00000", {rd_en, tr_start, coef_valid, mb_done, err}); end
        total++; if ({rd_idx, coef_idx} !== 10'd0) begin bad++; $display("FAIL reset_idx: got %h want 0", {rd_idx, coef_idx}); end
        total++; if ({tr_src, tr_ref} !== 256'd0) begin bad++; $display("FAIL reset_tr_operands: got %h want 0", {tr_src, tr_ref}); end
        total++; if (coef_data !== 192'd0) begin bad++; $display("FAIL reset_coef_data: got %h want 0", coef_data); end
        rst = 1'b0;
        step();
        total++; if (mb_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", mb_ready); end
    endtask

    task automatic test_full_job();
        fill_mem();
        run_job(24, 0, -1, 0, 0, 400);
        total++; if (timed_out || !acc_ok) begin bad++; $display("FAIL full_run: timed_out=%0d accepted=%0d want 0/1", timed_out, acc_ok); end
        total++; if (hs_cyc.size() != 24) begin bad++; $display("FAIL full_hs_count: got %0d want 24", hs_cyc.size()); end
        for (int k = 0; k < hs_cyc.size(); k++) begin
            total++; if (hs_cyc[k] != 6 + 6*k) begin bad++; $display("FAIL full_hs_cyc[%0d]: got %0d want %0d", k, hs_cyc[k], 6 + 6*k); end
            total++; if (hs_idx[k] != k) begin bad++; $display("FAIL full_hs_idx[%0d]: got %0d want %0d", k, hs_idx[k], k); end
            total++; if (hs_dat[k] !== fwd(src_mem[k], ref_mem[k])) begin bad++;
                $display("FAIL full_coef[%0d]: got %h want %h", k, hs_dat[k], fwd(src_mem[k], ref_mem[k])); end
        end
        for (int k = 0; k < rd_cyc.size(); k++) begin
            total++; if (rd_cyc[k] != 1 + 6*k || rd_ix[k] != k) begin bad++;
                $display("FAIL full_read[%0d]: got cyc %0d idx %0d want cyc %0d idx %0d", k, rd_cyc[k], rd_ix[k], 1 + 6*k, k); end
        end
        total++; if (done_cyc.size() != 1 || done_cyc[0] != 145) begin bad++;
            $display("FAIL full_mb_done: got %0d pulses first at %0d want 1 at 145", done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1); end
        total++; if (ready_cyc != 146) begin bad++; $display("FAIL full_mb_ready: got %0d want 146", ready_cyc); end
        total++; if (start_cnt != 24) begin bad++; $display("FAIL full_tr_start_count: got %0d want 24", start_cnt); end
    endtask

    task automatic test_backpressure();
        fill_mem();
        run_job(2, 0, 0, 5, 0, 200);
        total++; if (hs_cyc.size() != 2) begin bad++; $display("FAIL bp_hs_count: got %0d want 2", hs_cyc.size()); end
        if (hs_cyc.size() == 2) begin
            total++; if (hs_cyc[0] != 11 || hs_cyc[1] != 17) begin bad++;
                $display("FAIL bp_hs_cyc: got %0d,%0d want 11,17", hs_cyc[0], hs_cyc[1]); end
            total++; if (hs_dat[0] !== fwd(src_mem[0], ref_mem[0]) || hs_dat[1] !== fwd(src_mem[1], ref_mem[1])) begin bad++;
                $display("FAIL bp_coef: got %h want %h", hs_dat[0], fwd(src_mem[0], ref_mem[0])); end
        end
        total++; if (rd_cyc.size() != 2 || rd_cyc[rd_cyc.size()-1] != 12) begin bad++;
            $display("FAIL bp_read_after_hs: got %0d reads last at %0d want 2 last at 12", rd_cyc.size(), rd_cyc.size() > 0 ? rd_cyc[rd_cyc.size()-1] : -1); end
        total++; if (stall_cnt != 5 || stall_viol != 0 || drop_viol != 0) begin bad++;
            $display("FAIL bp_stall: got stalls %0d unstable %0d drops %0d want 5/0/0", stall_cnt, stall_viol, drop_viol); end
        total++; if (done_cyc.size() != 1 || done_cyc[0] != 18) begin bad++;
            $display("FAIL bp_mb_done: got %0d pulses want 1 at 18", done_cyc.size()); end
    endtask

    task automatic test_boundaries();
        int nbs [3] = '{1, 0, 31};
        for (int t = 0; t < 3; t++) begin
            int n;
            n = clamp_n(nbs[t]);
            fill_mem();
            run_job(nbs[t], 0, -1, 0, 0, 400);
            total++; if (hs_cyc.size() != n) begin bad++; $display("FAIL bound_hs_count(nblk=%0d): got %0d want %0d", nbs[t], hs_cyc.size(), n); end
            total++; if (done_cyc.size() != 1 || done_cyc[0] != 6*n + 1) begin bad++;
                $display("FAIL bound_mb_done(nblk=%0d): got %0d pulses first at %0d want at %0d", nbs[t], done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1, 6*n + 1); end
            total++; if (ready_cyc != 6*n + 2) begin bad++; $display("FAIL bound_mb_ready(nblk=%0d): got %0d want %0d", nbs[t], ready_cyc, 6*n + 2); end
            if (hs_cyc.size() == n) begin
                total++; if (hs_idx[n-1] != n - 1 || hs_dat[n-1] !== fwd(src_mem[n-1], ref_mem[n-1])) begin bad++;
                    $display("FAIL bound_last_block(nblk=%0d): got idx %0d want %0d", nbs[t], hs_idx[n-1], n - 1); end
            end
        end
    endtask

    task automatic test_timeout();
        fill_mem();
        tr_never = 1;
        run_job(4, 0, -1, 0, 0, 100);
        tr_never = 0;
        total++; if (hs_cyc.size() != 0 || stall_cnt != 0) begin bad++; $display("FAIL to_no_coef: got %0d valid cycles want 0", hs_cyc.size() + stall_cnt); end
        total++; if (done_cyc.size() != 1 || done_cyc[0] != 19) begin bad++;
            $display("FAIL to_mb_done: got %0d pulses first at %0d want 1 at 19", done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1); end
        total++; if (err_done !== 1'b1) begin bad++; $display("FAIL to_err_at_done: got %b want 1", err_done); end
        total++; if (start_cnt != 1 || ready_cyc != 20) begin bad++; $display("FAIL to_abort: got starts %0d ready %0d want 1/20", start_cnt, ready_cyc); end
        repeat (3) step();
        total++; if (err !== 1'b1 || mb_ready !== 1'b1) begin bad++; $display("FAIL to_err_sticky: got err %b ready %b want 1/1", err, mb_ready); end
        run_job(1, 0, -1, 0, 0, 100);
        total++; if (err_c1 !== 1'b0) begin bad++; $display("FAIL to_err_cleared: got %b want 0", err_c1); end
        total++; if (hs_cyc.size() != 1 || done_cyc.size() != 1 || done_cyc[0] != 7) begin bad++;
            $display("FAIL to_next_job: got %0d blocks %0d done pulses want 1/1 at 7", hs_cyc.size(), done_cyc.size()); end
    endtask

    task automatic test_reset_mid_job();
        fill_mem();
        mb_nblk    = 5'd10;
        mb_valid   = 1'b1;
        coef_ready = 1'b1;
        step();
        mb_valid = 1'b0;
        repeat (33) step();
        total++; if (mb_ready !== 1'b0 || coef_valid !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got ready %b valid %b want 0/0", mb_ready, coef_valid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (mb_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %b want 1", mb_ready); end
        total++; if ({rd_en, tr_start, coef_valid, mb_done, err, rd_idx, coef_idx} !== 15'd0) begin bad++;
            $display("FAIL rstmid_ctrl: got %h want 0", {rd_en, tr_start, coef_valid, mb_done, err, rd_idx, coef_idx}); end
        total++; if ({tr_src, tr_ref, coef_data} !== 448'd0) begin bad++; $display("FAIL rstmid_data: got nonzero want 0"); end
        step();
        total++; if (mb_ready !== 1'b1 || coef_valid !== 1'b0 || tr_start !== 1'b0 || rd_en !== 1'b0) begin bad++;
            $display("FAIL rstmid_late_done: got ready %b valid %b start %b rd %b want 1/0/0/0", mb_ready, coef_valid, tr_start, rd_en); end
        fill_mem();
        run_job(3, 0, -1, 0, 0, 100);
        total++; if (rd_ix.size() != 3 || rd_ix[0] != 0) begin bad++; $display("FAIL rstmid_restart_idx: got %0d reads want 3 from idx 0", rd_ix.size()); end
        total++; if (hs_idx.size() != 3 || hs_idx[2] != 2 || hs_dat[0] !== fwd(src_mem[0], ref_mem[0])) begin bad++;
            $display("FAIL rstmid_restart_blocks: got %0d blocks want 3", hs_idx.size()); end
    endtask

    task automatic test_protocol();
        spur = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (mb_ready !== 1'b1 || coef_valid !== 1'b0 || tr_start !== 1'b0) begin bad++;
                $display("FAIL proto_idle_spurious[%0d]: got ready %b valid %b start %b want 1/0/0", i, mb_ready, coef_valid, tr_start); end
        end
        fill_mem();
        run_job(2, 1, -1, 0, 0, 100);
        spur = 0;
        total++; if (hs_cyc.size() != 2 || hs_cyc[0] != 6 || hs_cyc[1] != 12) begin bad++;
            $display("FAIL proto_hs: got %0d handshakes want 2 at 6,12", hs_cyc.size()); end
        if (hs_dat.size() == 2) begin
            total++; if (hs_dat[1] !== fwd(src_mem[1], ref_mem[1])) begin bad++; $display("FAIL proto_coef: got %h want %h", hs_dat[1], fwd(src_mem[1], ref_mem[1])); end
        end
        total++; if (done_cyc.size() != 1 || done_cyc[0] != 13 || ready_cyc != 14) begin bad++;
            $display("FAIL proto_one_job: got %0d done pulses ready at %0d want 1 pulse at 13, ready 14", done_cyc.size(), ready_cyc); end
        total++; if (start_cnt != 2 || rd_cyc.size() != 2) begin bad++; $display("FAIL proto_pulses: got starts %0d reads %0d want 2/2", start_cnt, rd_cyc.size()); end
        step();
        total++; if (mb_ready !== 1'b1 || rd_en !== 1'b0) begin bad++; $display("FAIL proto_no_second_job: got ready %b rd %b want 1/0", mb_ready, rd_en); end
    endtask

    task automatic test_random_jobs();
        for (int j = 0; j < 4; j++) begin
            int nb;
            int n;
            nb = int'($urandom_range(0, 31));
            n  = clamp_n(nb);
            fill_mem();
            run_job(nb, 0, -1, 0, 1, 1200);
            total++; if (hs_idx.size() != n || timed_out) begin bad++; $display("FAIL rand_count(nblk=%0d): got %0d want %0d", nb, hs_idx.size(), n); end
            for (int k = 0; k < hs_idx.size(); k++) begin
                total++; if (hs_idx[k] != k || hs_dat[k] !== fwd(src_mem[k], ref_mem[k])) begin bad++;
                    $display("FAIL rand_block[%0d](nblk=%0d): got idx %0d want %0d", k, nb, hs_idx[k], k); end
            end
            total++; if (stall_viol != 0 || drop_viol != 0 || start_cnt != n) begin bad++;
                $display("FAIL rand_protocol(nblk=%0d): got unstable %0d drops %0d starts %0d want 0/0/%0d", nb, stall_viol, drop_viol, start_cnt, n); end
            total++; if (done_cyc.size() != 1 || hs_cyc.size() == 0 || done_cyc[0] != hs_cyc[hs_cyc.size()-1] + 1) begin bad++;
                $display("FAIL rand_mb_done(nblk=%0d): got %0d pulses want 1 right after last handshake", nb, done_cyc.size()); end
        end
    endtask

    initial begin
        test_reset();
        test_full_job();
        test_backpressure();
        test_boundaries();
        test_timeout();
        test_reset_mid_job();
        test_protocol();
        test_random_jobs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
